// File: rtl/winner_dispatch.sv
// Turns a registered comparator winner into a serial REWARD/DECAY command
// stream for the neuron update logic, followed by a refractory window.
`timescale 1ns/1ps
module winner_dispatch #(
    parameter int          p_width  = 22,
    parameter int unsigned p_min    = 1,
    parameter int unsigned p_refrac = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3:1]         i_index,
    input  logic [p_width-1:0] i_result,
    output logic               o_upd_valid,
    input  logic               i_upd_ready,
    output logic [3:1]         o_upd_sel,
    output logic               o_upd_reward,
    output logic [p_width-1:0] o_upd_value,
    output logic               o_nowin,
    output logic               o_busy
);

    localparam int CW = (p_refrac > 1) ? $clog2(p_refrac) : 1;
    localparam logic [p_width-1:0] MIN_VAL = p_width'(p_min);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REWARD,
        S_DECAY,
        S_REFRAC
    } state_t;

    state_t             state_q, state_d;
    logic [3:1]         win_q, win_d;
    logic [3:1]         lose_q, lose_d;
    logic [p_width-1:0] val_q, val_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               nowin_q, nowin_d;
    logic [3:1]         in_win;
    logic [3:1]         dec_sel;

    // Lowest set bit wins ties and orders the DECAY commands
    function automatic logic [3:1] lowbit(input logic [3:1] m);
        logic [3:1] r;
        r = 3'b000;
        priority case (1'b1)
            m[1]:    r = 3'b001;
            m[2]:    r = 3'b010;
            m[3]:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    assign in_win  = lowbit(i_index);
    assign dec_sel = lowbit(lose_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            lose_q  <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
            nowin_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            nowin_q <= nowin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        lose_d  = lose_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        nowin_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_index == 3'b000 || i_result < MIN_VAL) begin
                        nowin_d = 1'b1;
                    end else begin
                        win_d   = in_win;
                        lose_d  = ~in_win;
                        val_d   = i_result;
                        state_d = S_REWARD;
                    end
                end
            end
            S_REWARD: begin
                if (i_upd_ready) state_d = S_DECAY;
            end
            S_DECAY: begin
                if (i_upd_ready) begin
                    lose_d = lose_q & ~dec_sel;
                    if (lose_d == 3'b000) begin
                        if (p_refrac == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_REFRAC;
                            cnt_d   = CW'(p_refrac - 1);
                        end
                    end
                end
            end
            S_REFRAC: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_upd_valid  = 1'b0;
        o_upd_sel    = 3'b000;
        o_upd_reward = 1'b0;
        unique case (state_q)
            S_REWARD: begin
                o_upd_valid  = 1'b1;
                o_upd_sel    = win_q;
                o_upd_reward = 1'b1;
            end
            S_DECAY: begin
                o_upd_valid = 1'b1;
                o_upd_sel   = dec_sel;
            end
            default: ;
        endcase
    end

    assign o_ready     = (state_q == S_IDLE) & ~i_rst;
    assign o_busy      = (state_q != S_IDLE);
    assign o_nowin     = nowin_q;
    assign o_upd_value = val_q;

endmodule

// File: tb/tb_winner_dispatch.sv
// Directed bench for winner_dispatch: command stream is scoreboarded,
// timing, stall, reject, refractory and reset behaviour checked inline.
`timescale 1ns/1ps
module tb_winner_dispatch;

    localparam int W = 22;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [3:1]   i_index;
    logic [W-1:0] i_result;
    logic         o_upd_valid;
    logic         i_upd_ready;
    logic [3:1]   o_upd_sel;
    logic         o_upd_reward;
    logic [W-1:0] o_upd_value;
    logic         o_nowin;
    logic         o_busy;

    int tests = 0;
    int fails = 0;
    logic [W+3:0] sb[$];

    winner_dispatch #(.p_width(W), .p_min(1), .p_refrac(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_index     (i_index),
        .i_result    (i_result),
        .o_upd_valid (o_upd_valid),
        .i_upd_ready (i_upd_ready),
        .o_upd_sel   (o_upd_sel),
        .o_upd_reward(o_upd_reward),
        .o_upd_value (o_upd_value),
        .o_nowin     (o_nowin),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected command list of one accepted event
    task automatic push_event(input logic [3:1] idx, input logic [W-1:0] res);
        logic [3:1] w;
        w = idx[1] ? 3'b001 : (idx[2] ? 3'b010 : 3'b100);
        sb.push_back({w, 1'b1, res});
        for (int i = 0; i < 3; i++) begin
            if (!w[i+1]) sb.push_back({3'(1 << i), 1'b0, res});
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [3:1] idx, input logic [W-1:0] res);
        i_valid  = 1'b1;
        i_index  = idx;
        i_result = res;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_upd_valid && i_upd_ready) begin
            if (sb.size() == 0) begin
                chk("stray_cmd", {31'd0, o_upd_valid}, 32'd0);
            end else begin
                chk("cmd", 32'({o_upd_sel, o_upd_reward, o_upd_value}),
                    32'(sb.pop_front()));
            end
        end
    end

    initial begin
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_index     = 3'b000;
        i_result    = '0;
        i_upd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {31'd0, o_upd_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_ready_low", {31'd0, o_ready}, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_value", 32'(o_upd_value), 32'd0);

        // Single winner, exact timing with ready tied high
        push_event(3'b001, 22'd3);
        send(3'b001, 22'd3);
        chk("t2_rew_v", {30'd0, o_upd_valid, o_upd_reward}, 32'd3);
        chk("t2_rew_sel", 32'(o_upd_sel), 32'd1);
        tick();
        chk("t2_dec1", {30'd0, o_upd_valid, o_upd_reward}, 32'd2);
        tick();
        chk("t2_dec2", {30'd0, o_upd_valid, o_upd_reward}, 32'd2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t2_refrac", {29'd0, o_upd_valid, o_busy, o_ready}, 32'd2);
        end
        tick();
        chk("t2_ready", {30'd0, o_busy, o_ready}, 32'd1);
        drain();

        // Tie: lowest set bit wins
        push_event(3'b110, 22'd12);
        send(3'b110, 22'd12);
        chk("t3_sel", 32'(o_upd_sel), 32'd2);
        drain();
        wait_ready();

        // Backpressure in REWARD
        i_upd_ready = 1'b0;
        push_event(3'b111, 22'd18);
        send(3'b111, 22'd18);
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold", 32'({o_upd_valid, o_upd_reward, o_upd_sel,
                                o_upd_value}), 32'({2'b11, 3'b001, 22'd18}));
            tick();
        end
        i_upd_ready = 1'b1;
        drain();
        wait_ready();

        // Rejects
        send(3'b000, 22'd0);
        chk("t5_nowin_a", {29'd0, o_nowin, o_upd_valid, o_ready}, 32'd5);
        tick();
        chk("t5_pulse_end", {31'd0, o_nowin}, 32'd0);
        send(3'b100, 22'd0);
        chk("t5_nowin_b", {29'd0, o_nowin, o_upd_valid, o_busy}, 32'd4);
        tick();
        chk("t5_idle", {30'd0, o_nowin, o_upd_valid}, 32'd0);

        // Event during refractory is ignored
        push_event(3'b001, 22'd5);
        send(3'b001, 22'd5);
        repeat (3) tick();
        chk("t6_refrac", {30'd0, o_ready, o_busy}, 32'd1);
        send(3'b010, 22'd7);
        chk("t6_ignored", {31'd0, o_upd_valid}, 32'd0);
        drain();
        wait_ready();
        push_event(3'b010, 22'd7);
        send(3'b010, 22'd7);
        chk("t6_accept", 32'({o_upd_valid, o_upd_reward, o_upd_sel}),
            32'({2'b11, 3'b010}));
        drain();
        wait_ready();

        // Reset mid-DECAY drops the rest of the stream
        push_event(3'b001, 22'd9);
        send(3'b001, 22'd9);
        tick();
        chk("t1_in_decay", {30'd0, o_upd_valid, o_upd_reward}, 32'd2);
        i_rst = 1'b1;
        sb.delete();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t1_rst_out", 32'({o_upd_valid, o_upd_sel, o_upd_reward,
                                   o_nowin, o_busy, o_ready}), 32'd0);
            chk("t1_rst_val", 32'(o_upd_value), 32'd0);
        end
        i_rst = 1'b0;
        #1;
        chk("t1_ready", {31'd0, o_ready}, 32'd1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t1_quiet", {30'd0, o_upd_valid, o_busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
